// File: rtl/sqrt_share_arb.sv
// sqrt_share_arb: round-robin arbiter/sequencer sharing one square_root unit
// between NUM_REQ measurement paths, with a watchdog that recovers the unit.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr_i           synchronous abort and clear
//   req_i           level request per requester
//   req_data_i      packed operands, requester k at [k*OP_W +: OP_W]
//   gnt_o           one-hot grant pulse when the operand is captured
//   res_o           result, qualified by res_valid_o
//   res_valid_o     one-hot result pulse to the granted requester
//   res_err_o       result is a timeout abort (res_o = 0)
//   busy_o          high whenever not idle
//   sqrt_din_o      operand to square_root
//   sqrt_start_o    start pulse to square_root
//   sqrt_clr_o      clear to square_root
//   sqrt_dout_i     square_root result
//   sqrt_done_i     square_root result-valid pulse
module sqrt_share_arb #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BUF_BIT_W   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          clr_i,
  input  logic [NUM_REQ-1:0]                            req_i,
  input  logic [NUM_REQ*(2*DATA_W+BUF_BIT_W)-1:0]       req_data_i,
  output logic [NUM_REQ-1:0]                            gnt_o,
  output logic [DATA_W-1:0]                             res_o,
  output logic [NUM_REQ-1:0]                            res_valid_o,
  output logic                                          res_err_o,
  output logic                                          busy_o,
  output logic [2*DATA_W+BUF_BIT_W-1:0]                 sqrt_din_o,
  output logic                                          sqrt_start_o,
  output logic                                          sqrt_clr_o,
  input  logic [DATA_W-1:0]                             sqrt_dout_i,
  input  logic                                          sqrt_done_i
);

  localparam int unsigned OP_W  = 2*DATA_W + BUF_BIT_W;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RETURN  = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt_d;
  logic [DATA_W-1:0]  res_d;
  logic [NUM_REQ-1:0] res_valid_d;
  logic               res_err_d;
  logic               busy_d;
  logic [OP_W-1:0]    din_d;
  logic               start_d;
  logic               sqrt_clr_d;

  logic               found;
  logic [IDX_W-1:0]   sel;
  int                 scan_idx;

  // Unpack operands so the winner can be selected by index
  logic [OP_W-1:0] op_arr [NUM_REQ];
  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
    assign op_arr[g] = req_data_i[g*OP_W +: OP_W];
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      gnt_o        <= '0;
      res_o        <= '0;
      res_valid_o  <= '0;
      res_err_o    <= 1'b0;
      busy_o       <= 1'b0;
      sqrt_din_o   <= '0;
      sqrt_start_o <= 1'b0;
      sqrt_clr_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      gnt_o        <= gnt_d;
      res_o        <= res_d;
      res_valid_o  <= res_valid_d;
      res_err_o    <= res_err_d;
      busy_o       <= busy_d;
      sqrt_din_o   <= din_d;
      sqrt_start_o <= start_d;
      sqrt_clr_o   <= sqrt_clr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    res_d       = res_o;
    res_valid_d = '0;
    res_err_d   = 1'b0;
    din_d       = sqrt_din_o;
    start_d     = 1'b0;
    sqrt_clr_d  = 1'b0;
    found       = 1'b0;
    sel         = '0;
    scan_idx    = 0;

    // Round-robin scan starting at ptr
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      scan_idx = (int'(ptr_q) + i) % int'(NUM_REQ);
      if (!found && req_i[IDX_W'(scan_idx)]) begin
        found = 1'b1;
        sel   = IDX_W'(scan_idx);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          win_d   = sel;
          din_d   = op_arr[sel];
          gnt_d   = NUM_REQ'(1) << sel;
          start_d = 1'b1;
          ptr_d   = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
        end
      end
      S_GRANT: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Completion wins over the watchdog on the same cycle
        if (sqrt_done_i) begin
          state_d     = S_RETURN;
          res_d       = sqrt_dout_i;
          res_valid_d = NUM_REQ'(1) << win_q;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d     = S_RECOVER;
          res_d       = '0;
          res_valid_d = NUM_REQ'(1) << win_q;
          res_err_d   = 1'b1;
          sqrt_clr_d  = 1'b1;
        end
      end
      S_RETURN:  state_d = S_IDLE;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Abort: drop any in-flight operation without reporting it
    if (clr_i) begin
      state_d     = S_IDLE;
      ptr_d       = '0;
      cnt_d       = '0;
      gnt_d       = '0;
      res_d       = res_o;
      res_valid_d = '0;
      res_err_d   = 1'b0;
      din_d       = sqrt_din_o;
      start_d     = 1'b0;
      sqrt_clr_d  = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: doc/sqrt_share_arb.md
# sqrt_share_arb

Round-robin arbiter and sequencer that shares one `square_root` instance between up to `NUM_REQ` measurement paths (RMS, AC/DC channels, calibration). It accepts level requests carrying a mean-square operand, issues exactly one root computation at a time, returns the result to the winning requester with a one-hot valid pulse, and recovers the shared unit with a watchdog if it never completes. It sits between the per-channel averaging blocks and the single `square_root` datapath.

## Interface
- `NUM_REQ`, 4 — number of requesters, legal range 1..8
- `DATA_W`, 16 — result width, also the `square_root` `DATA_W`
- `BUF_BIT_W`, 8 — buffer exponent; operand width `OP_W = 2*DATA_W+BUF_BIT_W`
- `TIMEOUT_CYC`, 1024 — maximum WAIT cycles before abort, ≥ 2
- `clk`  in  1  system clock, all logic on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `clr_i`  in  1  synchronous abort and clear
- `req_i`  in  NUM_REQ  level request, one bit per requester
- `req_data_i`  in  NUM_REQ×OP_W  operand per requester, held stable while its request is high
- `gnt_o`  out  NUM_REQ  one-hot, one-cycle pulse when the operand is captured
- `res_o`  out  DATA_W  result, valid with `res_valid_o`
- `res_valid_o`  out  NUM_REQ  one-hot, one-cycle pulse addressed to the granted requester
- `res_err_o`  out  1  qualifies `res_valid_o`: timeout abort, `res_o` = 0
- `busy_o`  out  1  high in every state except IDLE
- `sqrt_din_o`  out  OP_W  operand to `square_root`
- `sqrt_start_o`  out  1  one-cycle start pulse (`din_update_i` of `square_root`)
- `sqrt_clr_o`  out  1  clear to `square_root`
- `sqrt_dout_i`  in  DATA_W  `square_root` result
- `sqrt_done_i`  in  1  `square_root` `dout_update_o`

## Operation
- States: IDLE, GRANT, WAIT, RETURN, RECOVER. All outputs are registered.
- Reset: state IDLE, round-robin pointer `ptr` = 0, counter = 0, every output 0, including `sqrt_din_o`.
- IDLE:
  - If `req_i` ≠ 0, select the first set bit scanning `ptr`, `ptr+1`, … modulo `NUM_REQ`.
  - Latch its index and `req_data_i` into `sqrt_din_o`.
  - Set `ptr` = winner+1, wrapping from `NUM_REQ-1` to 0.
  - Go to GRANT.
- GRANT (exactly one cycle):
  - `gnt_o[winner]` = 1 and `sqrt_start_o` = 1.
  - Clear the counter and go to WAIT.
- WAIT:
  - `sqrt_din_o` is held constant and the counter increments.
  - If `sqrt_done_i` = 1, latch `sqrt_dout_i` and go to RETURN.
  - Else, if counter = `TIMEOUT_CYC`-1, go to RECOVER.
  - Done has priority over timeout when both occur in the same cycle.
- RETURN (one cycle): `res_valid_o[winner]` = 1, `res_err_o` = 0, `res_o` = latched result; then IDLE.
- RECOVER (one cycle): `sqrt_clr_o` = 1, `res_valid_o[winner]` = 1, `res_err_o` = 1, `res_o` = 0; then IDLE.
- `sqrt_done_i` outside WAIT is ignored.
- Requester rules:
  - A requester drops `req_i` on the cycle after it sees `gnt_o`.
  - If it keeps the request high, it is treated as a new request in the next IDLE.
  - Withdrawing a request before grant is legal; no grant is issued for it.
- `clr_i` (priority over everything except reset):
  - In the next cycle: state IDLE, `ptr` = 0, counter = 0, all pulse outputs 0, `sqrt_clr_o` = 1 for that one cycle.
  - No `res_valid_o` is issued for the aborted operation.
- Counter width is `$clog2(TIMEOUT_CYC+1)` and never wraps.
- `res_o` and `sqrt_din_o` keep their last value outside their qualifying cycles.

## Timing
- Request seen high in IDLE at edge N: `gnt_o` and `sqrt_start_o` high in cycle N+1.
- `sqrt_done_i` high at edge M in WAIT: `res_valid_o` high in cycle M+1.
- Total latency is 3 cycles plus the `square_root` latency.
- Back-to-back throughput: next grant no earlier than 2 cycles after `res_valid_o` (RETURN → IDLE → GRANT).
- Timeout: `res_err_o` pulse `TIMEOUT_CYC`+1 cycles after `sqrt_start_o`.
- Reset asserted mid-operation: all outputs go to 0 immediately and asynchronously; no result is delivered after release.
- `NUM_REQ` = 1 degenerates to a sequencer; `ptr` stays 0.

## Test plan
- Single request: req 0 with operand 0x0000_0000_0100 (value 256), model `square_root` returns 16 after 20 cycles -> `gnt_o`=0001 at N+1, `sqrt_start_o` one pulse, `res_valid_o`=0001 with `res_o`=16 and `res_err_o`=0 at N+22.
- Fairness: all four requests held permanently high, operands 1, 4, 9, 16 -> grants 0, 1, 2, 3, 0 in order; results 1, 2, 3, 4, 1; never two grants before a result.
- Timeout: `TIMEOUT_CYC`=8, `sqrt_done_i` never asserted -> RECOVER reached, `sqrt_clr_o` one pulse, `res_valid_o` at the granted bit with `res_err_o`=1 and `res_o`=0 exactly 9 cycles after start; the next request then completes normally.
- Simultaneous events: `sqrt_done_i` on the final WAIT cycle -> normal RETURN with no error. `clr_i` in WAIT -> no `res_valid_o`, `sqrt_clr_o` pulses, `ptr` = 0, so the next grant goes to the lowest active request.
- Withdrawal and stray done: req 2 dropped before grant with req 3 still high -> only `gnt_o`=1000. A `sqrt_done_i` pulse while IDLE -> no `res_valid_o`.
- Reset mid-WAIT: `rst_n` low for 1 cycle -> all outputs 0 immediately, `busy_o` 0; a late `sqrt_done_i` after release produces no result.
